// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the streaming matrix-multiply engine.
package matmul_pkg;

  localparam int N_MAX      = 8;
  localparam int DATA_W_MAX = 8;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN
  } state_e;

  function automatic int acc_width(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int out_bytes(input int acc_w);
    return (acc_w + 7) / 8;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Shared multiply-accumulate unit; operands are two's-complement when MATMUL_SIGNED_EN is defined.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

`ifdef MATMUL_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  localparam int EXT_W = ACC_W - 2 * DATA_W;

  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]           acc_d, acc_q;

  // Unsigned operands are zero-extended, so the low product bits match either way.
  always_comb begin
    a_ext    = {{DATA_W{SIGNED_EN & a[DATA_W-1]}}, a};
    b_ext    = {{DATA_W{SIGNED_EN & b[DATA_W-1]}}, b};
    prod     = a_ext * b_ext;
    prod_ext = {{EXT_W{SIGNED_EN & prod[2*DATA_W-1]}}, prod};
    acc_d    = acc_q;
    if (en) begin
      acc_d = (clr ? '0 : acc_q) + prod_ext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_stream_engine.sv
// Streaming N x N matrix multiplier: load A,B words, compute with one MAC, drain C bytes LSB first.
// Optional build macro MATMUL_SIGNED_EN selects two's-complement arithmetic and sign-padded output.
module matmul_stream_engine
  import matmul_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done
);

`ifdef MATMUL_SIGNED_EN
  localparam logic PAD_SIGNED = 1'b1;
`else
  localparam logic PAD_SIGNED = 1'b0;
`endif

  localparam int ACC_W     = acc_width(N, DATA_W);
  localparam int OUT_BYTES = out_bytes(ACC_W);
  localparam int NN        = N * N;
  localparam int IDX_W     = $clog2(NN);
  localparam int IJK_W     = $clog2(N);
  localparam int BYTE_W    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NN - 1);
  localparam logic [IJK_W-1:0]  IJK_LAST  = IJK_W'(N - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(OUT_BYTES - 1);

  state_e             state_q, state_d;
  logic               sel_b_q, sel_b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IJK_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic               wr_q, wr_d, fin_q, fin_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]  mat_a_q [NN];
  logic [DATA_W-1:0]  mat_a_d [NN];
  logic [DATA_W-1:0]  mat_b_q [NN];
  logic [DATA_W-1:0]  mat_b_d [NN];
  logic [ACC_W-1:0]   mat_c_q [NN];
  logic [ACC_W-1:0]   mat_c_d [NN];

  logic                   mac_en;
  logic [IDX_W-1:0]       a_idx, b_idx;
  logic [ACC_W-1:0]       acc;
  logic [OUT_BYTES*8-1:0] elem_wide;
  logic [7:0]             out_byte;
  logic                   last_byte;

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en),
    .clr   (k_q == '0),
    .a     (mat_a_q[a_idx]),
    .b     (mat_b_q[b_idx]),
    .acc   (acc)
  );

  always_comb begin
    state_d  = state_q;
    sel_b_d  = sel_b_q;
    idx_d    = idx_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    byte_d   = byte_q;
    wr_d     = 1'b0;
    fin_d    = 1'b0;
    wr_idx_d = wr_idx_q;
    mat_a_d  = mat_a_q;
    mat_b_d  = mat_b_q;
    mat_c_d  = mat_c_q;
    mac_en   = 1'b0;
    a_idx    = IDX_W'(i_q) * IDX_W'(N) + IDX_W'(k_q);
    b_idx    = IDX_W'(k_q) * IDX_W'(N) + IDX_W'(j_q);

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (sel_b_q) mat_b_d[idx_q] = in_data;
          else         mat_a_d[idx_q] = in_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            sel_b_d = ~sel_b_q;
            if (sel_b_q) state_d = COMPUTE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        // C write trails the final k accumulation by one cycle; fin_q marks the tail cycle.
        if (wr_q) mat_c_d[wr_idx_q] = acc;
        if (fin_q) begin
          state_d = DRAIN;
        end else begin
          mac_en   = 1'b1;
          wr_d     = (k_q == IJK_LAST);
          wr_idx_d = IDX_W'(i_q) * IDX_W'(N) + IDX_W'(j_q);
          fin_d    = wr_d && (i_q == IJK_LAST) && (j_q == IJK_LAST);
          if (k_q == IJK_LAST) begin
            k_d = '0;
            if (j_q == IJK_LAST) begin
              j_d = '0;
              i_d = (i_q == IJK_LAST) ? '0 : i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (byte_q == BYTE_LAST) begin
            byte_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = LOAD;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Abort wins over any same-cycle handshake and leaves storage untouched.
    if (abort) begin
      state_d = LOAD;
      sel_b_d = 1'b0;
      idx_d   = '0;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      byte_d  = '0;
      wr_d    = 1'b0;
      fin_d   = 1'b0;
      mat_a_d = mat_a_q;
      mat_b_d = mat_b_q;
      mat_c_d = mat_c_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      sel_b_q  <= 1'b0;
      idx_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      byte_q   <= '0;
      wr_q     <= 1'b0;
      fin_q    <= 1'b0;
      wr_idx_q <= '0;
      for (int e = 0; e < NN; e++) begin
        mat_a_q[e] <= '0;
        mat_b_q[e] <= '0;
        mat_c_q[e] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sel_b_q  <= sel_b_d;
      idx_q    <= idx_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      byte_q   <= byte_d;
      wr_q     <= wr_d;
      fin_q    <= fin_d;
      wr_idx_q <= wr_idx_d;
      mat_a_q  <= mat_a_d;
      mat_b_q  <= mat_b_d;
      mat_c_q  <= mat_c_d;
    end
  end

  // Output byte: pad the element above ACC_W-1, then pick the current byte lane.
  always_comb begin
    elem_wide              = {(OUT_BYTES*8){PAD_SIGNED & mat_c_q[idx_q][ACC_W-1]}};
    elem_wide[ACC_W-1:0]   = mat_c_q[idx_q];
    out_byte               = '0;
    for (int bb = 0; bb < OUT_BYTES; bb++) begin
      if (byte_q == BYTE_W'(bb)) out_byte = elem_wide[bb*8 +: 8];
    end
  end

  assign last_byte  = (byte_q == BYTE_LAST) && (idx_q == IDX_LAST);
  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == DRAIN);
  assign out_data   = out_valid ? out_byte : 8'h00;
  assign busy       = (state_q != LOAD);
  assign frame_done = out_valid && out_ready && last_byte && !abort;

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Randomised self-checking bench for matmul_stream_engine against a plain-arithmetic matrix model.
module tb_matmul_stream_engine;

  localparam int N         = 3;
  localparam int DATA_W    = 8;
  localparam int NN        = N * N;
  localparam int OUT_BYTES = (2 * DATA_W + $clog2(N) + 7) / 8;

  typedef int mat_t [NN];
  typedef logic [7:0] bytes_t [$];
  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, abort, in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic [7:0]        out_data;
  logic              out_valid, out_ready, busy, frame_done;

  int   n_pass = 0, n_total = 0;
  int   fd_count = 0, exp_frames = 0, ready_pct = 100;
  exp_t exp_q[$];

  matmul_stream_engine #(.N(N), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic note_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic longint sval(input int x);
`ifdef MATMUL_SIGNED_EN
    return (x >= (1 << (DATA_W - 1))) ? longint'(x) - (longint'(1) << DATA_W) : longint'(x);
`else
    return longint'(x);
`endif
  endfunction

  // Reference: exact integer matrix product, each element split into little-endian bytes.
  function automatic void model(input mat_t a, input mat_t b, output bytes_t q);
    q = {};
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) s += sval(a[i*N+k]) * sval(b[k*N+j]);
        for (int bb = 0; bb < OUT_BYTES; bb++) q.push_back(8'(s >> (8 * bb)));
      end
    end
  endfunction

  task automatic send_word(input int d, input bit hold);
    int t = 0;
    if (!hold) begin
      while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    in_data  = DATA_W'(d);
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin @(posedge clk); #1; t++; end
    if (t >= 2000) note_fail("load_wait");
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic run_frame(input mat_t a, input mat_t b, input bit hold);
    bytes_t q;
    model(a, b, q);
    foreach (q[n]) exp_q.push_back('{data: q[n], last: (n == q.size() - 1)});
    exp_frames++;
    for (int w = 0; w < 2 * NN; w++) send_word((w < NN) ? a[w] : b[w-NN], hold);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 5000) begin @(posedge clk); #1; t++; end
    if (exp_q.size() > 0) note_fail("drain_wait");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_mat(output mat_t m);
    for (int e = 0; e < NN; e++) m[e] = $urandom_range(0, (1 << DATA_W) - 1);
  endtask

  initial begin : sink
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  initial begin : compare
    bit         stall_prev = 0;
    logic [7:0] stall_data = '0;
    int         comp_cyc = 0;
    bit         exp_fd;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 0;
        comp_cyc   = 0;
      end else begin
        exp_fd = 0;
        if (stall_prev) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, stall_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check("out_byte", out_data, e.data);
            exp_fd = e.last;
          end
        end
        check("frame_done", frame_done, exp_fd);
        if (frame_done) fd_count++;
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        if (busy && !out_valid) comp_cyc++;
        else begin
          if (busy && comp_cyc > 0) check("compute_len", comp_cyc, N * N * N + 1);
          comp_cyc = 0;
        end
      end
    end
  end

  initial begin : main
    mat_t   a, b, id_a, seq_b;
    bytes_t q;
    int     t;

    reset = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int e = 0; e < NN; e++) begin
      id_a[e]  = (e / N == e % N) ? 1 : 0;
      seq_b[e] = e + 1;
    end
    model(id_a, seq_b, q);
    check("model_id_b0", q[0], 8'h01);
    check("model_id_b1", q[1], 8'h00);
    check("model_id_b24", q[24], 8'h09);
    run_frame(id_a, seq_b, 0);
    wait_drain();

    for (int e = 0; e < NN; e++) begin a[e] = 255; b[e] = 255; end
    model(a, b, q);
`ifdef MATMUL_SIGNED_EN
    check("model_ff_b0", q[0], 8'h03);
    check("model_ff_b1", q[1], 8'h00);
    check("model_ff_b2", q[2], 8'h00);
`else
    check("model_ff_b0", q[0], 8'h03);
    check("model_ff_b1", q[1], 8'hFA);
    check("model_ff_b2", q[2], 8'h02);
`endif
    run_frame(a, b, 0);
    wait_drain();

    for (int e = 0; e < NN; e++) b[e] = 1;
    model(a, b, q);
`ifdef MATMUL_SIGNED_EN
    check("model_m1_b1", q[1], 8'hFF);
    check("model_m1_b2", q[2], 8'hFF);
`else
    check("model_m1_b1", q[1], 8'h02);
    check("model_m1_b2", q[2], 8'h00);
`endif
    check("model_m1_b0", q[0], 8'hFD);
    run_frame(a, b, 0);
    wait_drain();

    ready_pct = 30;
    run_frame(id_a, seq_b, 0);
    wait_drain();

    for (int f = 0; f < 4; f++) begin
      ready_pct = $urandom_range(20, 100);
      rand_mat(a);
      rand_mat(b);
      run_frame(a, b, 0);
      wait_drain();
    end

    // Abort a partial load; only the following frame may produce output.
    ready_pct = 100;
    for (int w = 0; w < 7; w++) send_word($urandom_range(0, 255), 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    rand_mat(a);
    rand_mat(b);
    run_frame(a, b, 0);
    wait_drain();

    // Back-to-back frames with in_valid held, then reset during the second drain.
    ready_pct = 60;
    rand_mat(a);
    rand_mat(b);
    run_frame(a, b, 1);
    rand_mat(a);
    rand_mat(b);
    run_frame(a, b, 1);
    t = 0;
    while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
    if (!out_valid) note_fail("second_drain_wait");
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    exp_frames--;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rand_mat(a);
    rand_mat(b);
    run_frame(a, b, 0);
    wait_drain();

    check("frame_count", fd_count, exp_frames);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
